// File: rtl/sram_pio_responder.sv
// PIO-driven SRAM responder: synchronizes host strobes and performs one RAM access per strobe.
// Optional power-up/reset clear sweep enabled by defining SRAM_CLEAR_ON_RESET_EN.
module sram_pio_responder #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipSelect,
  input  logic              enable,
  input  logic              readnWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              done,
  output logic              busy
);

  localparam int SW    = ADDR_W + DATA_W + 3;
  localparam int DEPTH = 1 << ADDR_W;

`ifdef SRAM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    CLEAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;
`endif

  state_t state_r, state_s;

  logic [SW-1:0]     pins_s;
  logic [SW-1:0]     synced_s;
  logic [SW-1:0]     sync_r [SYNC_STAGES];
  logic              cs_s, en_s, rnw_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;
  logic              strobe_s, strobe_d_r, rise_s;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              rnw_r;
  logic [DATA_W-1:0] dataout_r;
  logic              done_r;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              we_s;
  logic [ADDR_W-1:0] wa_s;
  logic [DATA_W-1:0] wd_s;

`ifdef SRAM_CLEAR_ON_RESET_EN
  logic              clr_pend_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              busy_r;
`endif

  // All PIO inputs travel together through the same synchronizer chain
  assign pins_s = {chipSelect, enable, readnWrite, address, dataIn};

  // Synchronizer shift chain for every PIO input bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= pins_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];
  assign cs_s     = synced_s[SW-1];
  assign en_s     = synced_s[SW-2];
  assign rnw_s    = synced_s[SW-3];
  assign addr_s   = synced_s[DATA_W +: ADDR_W];
  assign data_s   = synced_s[DATA_W-1:0];
  assign strobe_s = cs_s & en_s;
  assign rise_s   = strobe_s & ~strobe_d_r;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
`ifdef SRAM_CLEAR_ON_RESET_EN
        if (clr_pend_r) begin
          state_s = CLEAR;
        end else if (rise_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
`else
        if (rise_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
`endif
      end
      ACCESS: state_s = HOLD;
      HOLD: begin
        if (strobe_s) begin
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
`ifdef SRAM_CLEAR_ON_RESET_EN
      CLEAR: begin
        if (clr_ptr_r == {ADDR_W{1'b1}}) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // RAM write port select: host write in ACCESS, or the clear sweep
  always_comb begin
    we_s = 1'b0;
    wa_s = addr_r;
    wd_s = data_r;
    if ((state_r == ACCESS) && !rnw_r) begin
      we_s = 1'b1;
`ifdef SRAM_CLEAR_ON_RESET_EN
    end else if (state_r == CLEAR) begin
      we_s = 1'b1;
      wa_s = clr_ptr_r;
      wd_s = '0;
`endif
    end else begin
      we_s = 1'b0;
    end
  end

  // RAM array; contents deliberately untouched by rst
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // State, request latch, read data and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      strobe_d_r <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      rnw_r      <= 1'b0;
      dataout_r  <= '0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      strobe_d_r <= strobe_s;
      if ((state_r == IDLE) && (state_s == ACCESS)) begin
        addr_r <= addr_s;
        data_r <= data_s;
        rnw_r  <= rnw_s;
      end
      // Read data lands in dataOut on the same edge that enters HOLD
      if ((state_r == ACCESS) && rnw_r) begin
        dataout_r <= mem_r[addr_r];
      end
      done_r <= (state_s == HOLD);
    end
  end

`ifdef SRAM_CLEAR_ON_RESET_EN
  // Clear sweep pointer, pending flag and busy flag; rst restarts the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend_r <= 1'b1;
      clr_ptr_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      clr_pend_r <= 1'b0;
      if (state_r == CLEAR) begin
        clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        clr_ptr_r <= '0;
      end
      busy_r <= (state_s == CLEAR);
    end
  end

  assign busy = busy_r;
`else
  assign busy = 1'b0;
`endif

  assign dataOut = dataout_r;
  assign done    = done_r;

endmodule

// File: tb/tb_sram_pio_responder.sv
// Self-checking bench for sram_pio_responder: directed scenarios plus randomized accesses
// checked against an array model of the RAM and the host-visible dataOut.
module tb_sram_pio_responder;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int SS     = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT    = SS + 2;
  localparam int FALL   = SS + 1;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              chipSelect = 1'b0;
  logic              enable     = 1'b0;
  logic              readnWrite = 1'b0;
  logic [ADDR_W-1:0] address    = '0;
  logic [DATA_W-1:0] dataIn     = '0;
  logic [DATA_W-1:0] dataOut;
  logic              done;
  logic              busy;

  sram_pio_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .chipSelect(chipSelect), .enable(enable),
    .readnWrite(readnWrite), .address(address), .dataIn(dataIn),
    .dataOut(dataOut), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mdl [DEPTH];
  bit                mval [DEPTH];
  logic [DATA_W-1:0] mout = '0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_access(input logic rnw, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, output int lat);
    readnWrite = rnw;
    address    = a;
    dataIn     = d;
    chipSelect = 1'b1;
    tick(1);
    enable = 1'b1;
    lat    = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_access(output int fall);
    enable = 1'b0;
    fall   = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (done === 1'b0) begin
        fall = i;
        break;
      end
    end
    chipSelect = 1'b0;
    tick(1);
  endtask

  // One full host transaction; model updated from the host's point of view
  task automatic run_access(input logic rnw, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int lat,
                            output int fall, output logic [DATA_W-1:0] rd);
    start_access(rnw, a, d, lat);
    rd = dataOut;
    finish_access(fall);
    if (!rnw) begin
      mdl[a]  = d;
      mval[a] = 1'b1;
    end else begin
      mout = mdl[a];
    end
  endtask

  task automatic post_reset();
`ifdef SRAM_CLEAR_ON_RESET_EN
    int cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (busy === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    total++;
    if (cnt != DEPTH) begin
      bad++;
      $display("FAIL busy_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]  = '0;
      mval[i] = 1'b1;
    end
`else
    int hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL busy_idle got=%0d exp=0", hi);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total += 3;
    if (dataOut !== 8'h00) begin bad++; $display("FAIL rst_dataout got=%h exp=00", dataOut); end
    if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst  = 1'b0;
    mout = '0;
    post_reset();
  endtask

  task automatic test_write_read();
    int lat, fall;
    logic [DATA_W-1:0] rd;
    run_access(1'b0, 11'h000, 8'hA5, lat, fall, rd);
    total += 2;
    if (lat != LAT)   begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
    if (fall != FALL) begin bad++; $display("FAIL wr_done_fall got=%0d exp=%0d", fall, FALL); end
    run_access(1'b1, 11'h000, 8'h00, lat, fall, rd);
    total += 3;
    if (lat != LAT)   begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
    if (rd !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h exp=a5", rd); end
    if (fall != FALL) begin bad++; $display("FAIL rd_done_fall got=%0d exp=%0d", fall, FALL); end
  endtask

  task automatic test_top_address();
    int lat, fall;
    logic [DATA_W-1:0] rd;
    run_access(1'b0, 11'h7FF, 8'h3C, lat, fall, rd);
    run_access(1'b0, 11'h000, 8'hC3, lat, fall, rd);
    run_access(1'b1, 11'h7FF, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'h3C) begin bad++; $display("FAIL top_read got=%h exp=3c", rd); end
    run_access(1'b1, 11'h000, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'hC3) begin bad++; $display("FAIL low_read got=%h exp=c3", rd); end
  endtask

  task automatic test_no_select_and_held();
    int lat, fall, dhi, errs;
    logic [DATA_W-1:0] rd;
    run_access(1'b0, 11'h010, 8'h11, lat, fall, rd);
    run_access(1'b0, 11'h124, 8'h99, lat, fall, rd);
    chipSelect = 1'b0; readnWrite = 1'b0; address = 11'h010; dataIn = 8'hFF;
    enable = 1'b1;
    dhi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (done !== 1'b0 || dataOut !== mout) dhi++;
    end
    enable = 1'b0;
    tick(3);
    total++;
    if (dhi != 0) begin bad++; $display("FAIL nosel_quiet got=%0d exp=0", dhi); end
    run_access(1'b1, 11'h010, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'h11) begin bad++; $display("FAIL nosel_mem got=%h exp=11", rd); end
    // Held strobe: request changes after done must be ignored
    chipSelect = 1'b1; readnWrite = 1'b0; address = 11'h123; dataIn = 8'h77;
    tick(1);
    enable = 1'b1;
    errs = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 6) begin
        address = 11'h124;
        dataIn  = 8'h88;
      end
      if (done !== ((i >= LAT) ? 1'b1 : 1'b0)) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL held_done got=%0d exp=0", errs); end
    finish_access(fall);
    mdl[11'h123] = 8'h77; mval[11'h123] = 1'b1;
    run_access(1'b1, 11'h123, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'h77) begin bad++; $display("FAIL held_write got=%h exp=77", rd); end
    run_access(1'b1, 11'h124, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'h99) begin bad++; $display("FAIL held_norepeat got=%h exp=99", rd); end
  endtask

  task automatic test_short_strobe();
    int lat, fall, pulses;
    logic [DATA_W-1:0] rd;
    run_access(1'b0, 11'h005, 8'h5A, lat, fall, rd);
    chipSelect = 1'b1; readnWrite = 1'b1; address = 11'h005;
    tick(1);
    enable = 1'b1;
    tick(SS);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (done === 1'b1) pulses++;
    end
    chipSelect = 1'b0;
    tick(1);
    mout = 8'h5A;
    total += 2;
    if (pulses != 1)       begin bad++; $display("FAIL short_pulse got=%0d exp=1", pulses); end
    if (dataOut !== 8'h5A) begin bad++; $display("FAIL short_data got=%h exp=5a", dataOut); end
  endtask

  task automatic test_reset_mid_access();
    int lat, fall;
    logic [DATA_W-1:0] rd;
    start_access(1'b1, 11'h005, 8'h00, lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL rma_latency got=%0d exp=%0d", lat, LAT); end
    rst = 1'b1; enable = 1'b0; chipSelect = 1'b0;
    #1;
    total += 2;
    if (dataOut !== 8'h00) begin bad++; $display("FAIL rma_dataout got=%h exp=00", dataOut); end
    if (done !== 1'b0)     begin bad++; $display("FAIL rma_done got=%b exp=0", done); end
    tick(2);
    rst  = 1'b0;
    mout = '0;
    post_reset();
    run_access(1'b1, 11'h005, 8'h00, lat, fall, rd);
    total++;
    if (rd !== mdl[11'h005]) begin bad++; $display("FAIL rma_retain got=%h exp=%h", rd, mdl[11'h005]); end
  endtask

  task automatic test_back_to_back();
    int lat, fall;
    logic [3:0] pat;
    start_access(1'b0, 11'h020, 8'hAB, lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    mdl[11'h020] = 8'hAB; mval[11'h020] = 1'b1;
    enable = 1'b0;
    tick(1);
    readnWrite = 1'b1;
    enable = 1'b1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pat = {pat[2:0], done};
    end
    total += 2;
    if (pat !== 4'b1001)   begin bad++; $display("FAIL b2b_done got=%b exp=1001", pat); end
    if (dataOut !== 8'hAB) begin bad++; $display("FAIL b2b_data got=%h exp=ab", dataOut); end
    finish_access(fall);
    mout = 8'hAB;
  endtask

  task automatic test_random();
    int lat, fall, errs;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, rd, exp;
    logic rnw;
    errs = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) a = ADDR_W'(DEPTH - 1 - int'($urandom_range(0, 3)));
      else a = ADDR_W'($urandom_range(0, 31));
      d   = DATA_W'($urandom_range(0, 255));
      rnw = ($urandom_range(0, 1) == 1) && mval[a];
      exp = rnw ? mdl[a] : mout;
      run_access(rnw, a, d, lat, fall, rd);
      total++;
      if (lat != LAT || fall != FALL || rd !== exp) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL rand_%0d a=%h rnw=%b lat=%0d fall=%0d got=%h exp=%h",
                               n, a, rnw, lat, fall, rd, exp);
      end
    end
  endtask

`ifdef SRAM_CLEAR_ON_RESET_EN
  task automatic test_clear();
    int cnt, dhi, lat, fall;
    logic [DATA_W-1:0] rd;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cnt = 0;
    dhi = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (done !== 1'b0) dhi++;
      if (busy === 1'b1) begin
        cnt++;
        if (cnt == 100) begin
          chipSelect = 1'b1; readnWrite = 1'b0; address = 11'h7FF; dataIn = 8'h77; enable = 1'b1;
        end
      end else if (cnt > 0) break;
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (done !== 1'b0) dhi++;
    end
    enable = 1'b0; chipSelect = 1'b0;
    tick(3);
    mout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0; mval[i] = 1'b1;
    end
    total += 2;
    if (cnt != DEPTH) begin bad++; $display("FAIL clr_busy got=%0d exp=%0d", cnt, DEPTH); end
    if (dhi != 0)     begin bad++; $display("FAIL clr_ignore got=%0d exp=0", dhi); end
    run_access(1'b1, 11'h7FF, 8'h00, lat, fall, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL clr_top got=%h exp=00", rd); end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
    test_reset();
    test_write_read();
    test_top_address();
    test_no_select_and_held();
    test_short_strobe();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
`ifdef SRAM_CLEAR_ON_RESET_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_pio_responder.md
Name: sram_pio_responder

Overview:
- Memory-side responder for the PIO-driven SRAM bus: a 2^ADDR_W x DATA_W on-chip RAM that serves read and write strobes from the Nios PIO outputs (chipSelect, enable, readnWrite, address, data).
- PIO outputs change with arbitrary software timing, so the block synchronizes them, detects each access strobe and executes exactly one access per strobe.
- Returns read data and a done flag that software polls through PIO inputs.

Parameters:
- ADDR_W, 11, address width; depth = 2^ADDR_W.
- DATA_W, 8, data width.
- SYNC_STAGES, 2, synchronizer flops per PIO input; legal values 2 to 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- chipSelect  input  1  PIO chip select; active high.
- enable  input  1  PIO access strobe; active high.
- readnWrite  input  1  1 = read, 0 = write.
- address  input  ADDR_W  word address.
- dataIn  input  DATA_W  write data from the host.
- dataOut  output  DATA_W  read data to the host; registered.
- done  output  1  access complete; high until strobe released.
- busy  output  1  clear sweep in progress; constant 0 without the optional feature.

Behaviour:
Reset values:
- rst asserted: dataOut=0, done=0, busy=0, FSM=IDLE, sync flops=0.
- RAM contents are not altered by reset, except as described under Optional Feature.
Input capture and strobe detection:
- All inputs pass through SYNC_STAGES flops.
- strobe_s = chipSelect_s & enable_s; rise = strobe_s & ~strobe_d.
- Host protocol: address, dataIn and readnWrite are stable before enable rises and held until done is seen.
FSM states:
- IDLE: waits for rise. On rise, latch address_s, dataIn_s and readnWrite_s, then go to ACCESS.
- ACCESS: exactly one cycle.
  - Write: mem[addr] <= data.
  - Read: rdata <= mem[addr].
  - Always goes to HOLD.
- HOLD:
  - done=1.
  - On a read, dataOut <= rdata on entry to HOLD; otherwise dataOut is unchanged.
  - Stays in HOLD while strobe_s=1; goes to IDLE with done=0 on the cycle strobe_s=0.
Latency:
- Pin rise sampled at edge 0; strobe_s=1 after edge SYNC_STAGES-1; ACCESS at edge SYNC_STAGES; done=1 after edge SYNC_STAGES+1.
- Default: done rises 3 cycles after the first sampling edge.
Boundary conditions:
- Strobe dropped during ACCESS: the access still completes. HOLD is entered with done=1 for one cycle, then IDLE.
- Strobe held high continuously: exactly one access; no repeat.
- A new access requires strobe_s low for at least one cycle, then a new rise.
- enable high with chipSelect low: no access; done stays 0; dataOut held.
- chipSelect dropping while enable high counts as strobe release.
- Input changes while in HOLD are ignored.
- Address 2^ADDR_W-1 is valid. There is no wrap or bounds logic; the full range is addressable.
- dataOut keeps the last read value across writes and idle periods. It is cleared only by rst.
- rst mid-access: FSM returns to IDLE immediately. A write is only committed if its ACCESS edge occurred before rst.

Optional Feature:
- Macro: SRAM_CLEAR_ON_RESET_EN.
- With the macro:
  - On rst deassertion, FSM enters CLEAR, busy=1, and a sweep writes 0 to addresses 0 through 2^ADDR_W-1, one per cycle.
  - busy falls the cycle after the final write (2^ADDR_W cycles of busy).
  - Strobes seen during CLEAR are ignored, and strobe_d tracks normally, so a strobe already high at end of sweep does not start an access.
  - rst during CLEAR restarts the sweep from 0.
- Without the macro: no CLEAR state; busy tied 0; RAM contents are undefined after power-up and retained across rst.

Test Plan:
- Write then read: write 0xA5 to 0x000 (cs=1, rnw=0, strobe), release, then read 0x000. Required: done rises 3 cycles after the strobe is sampled; dataOut=0xA5; done falls one cycle after strobe release.
- Top address: write 0x3C to 0x7FF, write 0xC3 to 0x000, read 0x7FF. Required: dataOut=0x3C, and 0x000 still reads 0xC3.
- No-select and held strobe: enable=1 with cs=0 and a write of 0xFF to 0x010 → done stays 0 and 0x010 keeps its prior value. Then cs=1 held high for 20 cycles → exactly one write, and done stays 1 for the whole hold.
- Short strobe: strobe held for exactly SYNC_STAGES cycles on a read of 0x005 holding 0x5A. Required: access completes, dataOut=0x5A, done pulses for 1 cycle.
- Reset mid-access: assert rst during HOLD after a read of 0x5A. Required: dataOut=0, done=0; a subsequent read of 0x005 returns 0x5A (without SRAM_CLEAR_ON_RESET_EN).
- With SRAM_CLEAR_ON_RESET_EN: after rst release, busy=1 for exactly 2048 cycles; a strobe during CLEAR is ignored; afterwards a read of 0x7FF returns 0x00.
